// File: rtl/axis_labcontrol_bus_arbiter.sv
// axis_labcontrol_bus_arbiter
// Round-robin arbiter over N_CH AXI-Stream slave channels. The granted word is
// driven onto the LabControl DIO bus as one write cycle with setup, strobe and
// hold phases, so a receiver behind a 2-stage synchronizer can sample it.
//
// Handshake: a channel's word is taken on a rising clock edge where
// s_axis_tvalid[i] and s_axis_tready[i] are both 1. tready is only raised in
// IDLE, for at most one channel, and does not depend on anything the channel
// does after raising tvalid. tvalid may drop at any time before that edge.
module axis_labcontrol_bus_arbiter #(
  parameter int N_CH          = 4,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  localparam int GW           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                s_axis_aclk,
  input  logic                s_axis_areset,
  input  logic [32*N_CH-1:0]  s_axis_tdata,
  input  logic [N_CH-1:0]     s_axis_tvalid,
  output logic [N_CH-1:0]     s_axis_tready,
  input  logic                enable,
  output logic [7:0]          DIOA,
  output logic [7:0]          DIOB,
  output logic [7:0]          DIOC,
  output logic [7:0]          DIOD,
  output logic                busy,
  output logic [GW-1:0]       grant_id,
  output logic [1:0]          dbg_state
);

  localparam int CNT_MAX_SU = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_SU > HOLD_CYCLES) ? CNT_MAX_SU : HOLD_CYCLES;
  // The counter holds (phase length - 1), so CNT_MAX values need clog2(CNT_MAX) bits.
  localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [GW-1:0] LAST_CH     = GW'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   last_grant_q;
  logic            found;
  logic [GW-1:0]   sel;
  logic [26:0]     sel_word;
  logic            hs;
  logic [15:0]     data_q;
  logic [7:0]      addr_q;
  logic [2:0]      sub_q;
  logic            strobe_q;
  logic [5*N_CH-1:0] unused_tdata_hi;

  // Round-robin search: first valid channel starting just after the last grant.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_word = '0;
    for (int i = 1; i <= N_CH; i++) begin
      for (int j = 0; j < N_CH; j++) begin
        if (!found && s_axis_tvalid[j] && (j == (int'(last_grant_q) + i) % N_CH)) begin
          found    = 1'b1;
          sel      = GW'(j);
          sel_word = s_axis_tdata[32*j +: 27];
        end
      end
    end
  end

  // Bits [31:27] of every channel carry nothing for the bus.
  always_comb begin
    unused_tdata_hi = '0;
    for (int j = 0; j < N_CH; j++) begin
      unused_tdata_hi[5*j +: 5] = s_axis_tdata[32*j+27 +: 5];
    end
  end

  // Next-state logic: grant in IDLE, then count through setup/strobe/hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hs      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && found && !s_axis_areset) begin
          hs      = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Ready goes to the granted channel only, in the arbitration cycle itself.
  always_comb begin
    s_axis_tready = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (hs && (sel == GW'(j))) s_axis_tready[j] = 1'b1;
    end
  end

  // FSM state and phase counter.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered bus word, strobe and grant bookkeeping; a reset drops any word in flight.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      data_q       <= '0;
      addr_q       <= '0;
      sub_q        <= '0;
      strobe_q     <= 1'b0;
      grant_id     <= '0;
      last_grant_q <= LAST_CH;
    end else begin
      strobe_q <= (state_d == ST_STROBE);
      if (hs) begin
        data_q       <= sel_word[15:0];
        addr_q       <= sel_word[23:16];
        sub_q        <= sel_word[26:24];
        grant_id     <= sel;
        last_grant_q <= sel;
      end
    end
  end

  assign DIOA      = data_q[7:0];
  assign DIOB      = data_q[15:8];
  assign DIOC      = addr_q;
  assign DIOD      = {3'b000, sub_q, 1'b0, strobe_q};
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
